// File: rtl/seg_stream_arbiter.sv
// Frame-synchronous selector between the fixed- and adaptive-threshold segmentation streams.
// Changes source only on a vsync falling edge and reports frame completion and pixel-count errors.
module seg_stream_arbiter #(
  parameter int H_DISP      = 1440,
  parameter int V_DISP      = 1080,
  parameter int AUTO_TOGGLE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_req,
  input  logic       fix_hsync,
  input  logic       fix_vsync,
  input  logic [7:0] fix_data,
  input  logic       fix_de,
  input  logic       adp_hsync,
  input  logic       adp_vsync,
  input  logic [7:0] adp_data,
  input  logic       adp_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [7:0] out_data,
  output logic       out_de,
  output logic       out_src,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int FRAME_PIX = H_DISP * V_DISP;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] FRAME_PIX_C = CNT_W'(FRAME_PIX);
  localparam logic [CNT_W-1:0] LAST_PIX_C  = CNT_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWITCH
  } state_e;

  state_e           state_q, state_d;
  logic             src_q, src_d;
  logic             fix_vs_q, adp_vs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             clr_cnt, chk_frame;

  logic             hsync_d, vsync_d, de_d, done_d, err_d;
  logic [7:0]       data_d;

  logic fs_fix, fs_adp, fs_cur, fs_tgt, tgt;

  assign fs_fix = fix_vs_q & ~fix_vsync;
  assign fs_adp = adp_vs_q & ~adp_vsync;
  // Before the first lock there is no current source to toggle from, so IDLE follows sel_req.
  assign tgt    = (state_q != ST_IDLE && AUTO_TOGGLE != 0) ? ~src_q : sel_req;
  assign fs_cur = src_q ? fs_adp : fs_fix;
  assign fs_tgt = tgt   ? fs_adp : fs_fix;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      src_q    <= 1'b0;
      fix_vs_q <= 1'b0;
      adp_vs_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      fix_vs_q <= fix_vsync;
      adp_vs_q <= adp_vsync;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    clr_cnt   = 1'b0;
    chk_frame = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SWITCH: begin
        if (fs_tgt) begin
          state_d = ST_RUN;
          src_d   = tgt;
          clr_cnt = 1'b1;
        end
      end
      ST_RUN: begin
        if (fs_cur) begin
          chk_frame = 1'b1;
          if (tgt == src_q || fs_tgt) begin
            src_d   = tgt;
            clr_cnt = 1'b1;
          end else begin
            state_d = ST_SWITCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output is driven from the next state so the vsync-fall cycle of an accepted frame is forwarded.
  always_comb begin
    hsync_d = 1'b1;
    vsync_d = 1'b1;
    de_d    = 1'b0;
    data_d  = 8'h00;
    if (state_d == ST_RUN) begin
      hsync_d = src_d ? adp_hsync : fix_hsync;
      vsync_d = src_d ? adp_vsync : fix_vsync;
      de_d    = src_d ? adp_de    : fix_de;
      data_d  = src_d ? adp_data  : fix_data;
    end
    cnt_base = clr_cnt ? '0 : cnt_q;
    cnt_d    = (de_d && cnt_base != CNT_MAX) ? cnt_base + 1'b1 : cnt_base;
    done_d   = de_d && (cnt_base == LAST_PIX_C);
    err_d    = chk_frame && (cnt_q != FRAME_PIX_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hsync  <= 1'b1;
      out_vsync  <= 1'b1;
      out_de     <= 1'b0;
      out_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_hsync  <= hsync_d;
      out_vsync  <= vsync_d;
      out_de     <= de_d;
      out_data   <= data_d;
      frame_done <= done_d;
      frame_err  <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_src = src_q;

endmodule

// File: tb/tb_seg_stream_arbiter.sv
// Randomized bench for seg_stream_arbiter: a selectable instance and an auto-toggling instance
// on aligned streams, both compared every cycle against a frame-rule reference model.
module tb_seg_stream_arbiter;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;
  localparam int P = 64;
  localparam int CYCLES = 1400;
  localparam logic [13:0] RST_VEC = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       sel_req;
  logic       fix_hs, fix_vs, fix_de, adp_hs, adp_vs, adp_de, al_hs, al_vs, al_de;
  logic [7:0] fix_d, adp_d, al_d;

  logic       o_hs, o_vs, o_de, o_src, o_done, o_err;
  logic [7:0] o_data;
  logic       a_hs, a_vs, a_de, a_src, a_done, a_err;
  logic [7:0] a_data;

  seg_stream_arbiter #(.H_DISP(H), .V_DISP(V), .AUTO_TOGGLE(0)) dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req),
    .fix_hsync(fix_hs), .fix_vsync(fix_vs), .fix_data(fix_d), .fix_de(fix_de),
    .adp_hsync(adp_hs), .adp_vsync(adp_vs), .adp_data(adp_d), .adp_de(adp_de),
    .out_hsync(o_hs), .out_vsync(o_vs), .out_data(o_data), .out_de(o_de),
    .out_src(o_src), .frame_done(o_done), .frame_err(o_err)
  );

  seg_stream_arbiter #(.H_DISP(H), .V_DISP(V), .AUTO_TOGGLE(1)) dut_at (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req),
    .fix_hsync(fix_hs), .fix_vsync(fix_vs), .fix_data(fix_d), .fix_de(fix_de),
    .adp_hsync(al_hs), .adp_vsync(al_vs), .adp_data(al_d), .adp_de(al_de),
    .out_hsync(a_hs), .out_vsync(a_vs), .out_data(a_data), .out_de(a_de),
    .out_src(a_src), .frame_done(a_done), .frame_err(a_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Pixels in the last line of frame f of stream sid; fix frames 8 and 10 are short and long.
  function automatic int last_line_pix(input int sid, input int f);
    if (sid == 0 && f == 8)  return H - 2;
    if (sid == 0 && f == 10) return H + 1;
    return H;
  endfunction

  // Frame of P cycles: vsync low 3 cycles, then V lines of 14 cycles (hsync 2, porch 2, pixels).
  task automatic stream_ctl(input int c, input int offset, input int sid,
                            output logic hs, output logic vs, output logic de);
    int t, f, k, l, o, np;
    hs = 1'b1; vs = 1'b1; de = 1'b0;
    if (c >= offset) begin
      t = c - offset;
      f = t / P;
      k = t % P;
      vs = (k < 3) ? 1'b0 : 1'b1;
      if (k >= 8) begin
        l  = (k - 8) / 14;
        o  = (k - 8) % 14;
        np = (l == V - 1) ? last_line_pix(sid, f) : H;
        hs = (o < 2) ? 1'b0 : 1'b1;
        de = (o >= 4 && o < 4 + np);
      end
    end
  endtask

  // Reference model: "locked" means a source has been chosen since reset; "fwd" means the
  // chosen source's frame is currently being passed through.
  bit          m_fwd[2], m_locked[2], m_src[2], m_pvf[2], m_pva[2];
  int          m_cnt[2];
  logic [13:0] m_exp[2];
  int          m_done_cnt = 0, m_err_cnt = 0, d_done_cnt = 0, d_err_cnt = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fwd[i] = 0; m_locked[i] = 0; m_src[i] = 0; m_pvf[i] = 0; m_pva[i] = 0;
      m_cnt[i] = 0; m_exp[i] = RST_VEC;
    end
  endtask

  task automatic model_step(input int i, input bit auto_t, input logic sel,
                            input logic fhs, input logic fvs, input logic fde, input logic [7:0] fd,
                            input logic ahs, input logic avs, input logic ade, input logic [7:0] ad);
    bit fsf, fsa, tgt, fs_src, fs_tgt, err, done;
    logic hs, vs, de;
    logic [7:0] d;
    fsf = m_pvf[i] && !fvs;
    fsa = m_pva[i] && !avs;
    m_pvf[i] = fvs;
    m_pva[i] = avs;
    tgt    = (auto_t && m_locked[i]) ? !m_src[i] : sel;
    fs_src = m_src[i] ? fsa : fsf;
    fs_tgt = tgt ? fsa : fsf;
    err = 0;
    if (m_fwd[i] && fs_src) begin
      err = (m_cnt[i] != N);
      if (tgt == m_src[i] || fs_tgt) begin
        m_src[i] = tgt;
        m_cnt[i] = 0;
      end else begin
        m_fwd[i] = 0;
      end
    end else if (!m_fwd[i] && fs_tgt) begin
      m_src[i] = tgt; m_cnt[i] = 0; m_fwd[i] = 1; m_locked[i] = 1;
    end
    hs = 1'b1; vs = 1'b1; de = 1'b0; d = 8'h00; done = 0;
    if (m_fwd[i]) begin
      hs = m_src[i] ? ahs : fhs;
      vs = m_src[i] ? avs : fvs;
      de = m_src[i] ? ade : fde;
      d  = m_src[i] ? ad  : fd;
      if (de) begin
        m_cnt[i]++;
        done = (m_cnt[i] == N);
      end
    end
    if (i == 0 && done) m_done_cnt++;
    if (i == 0 && err)  m_err_cnt++;
    m_exp[i] = {hs, vs, de, d, m_src[i], done, err};
  endtask

  initial begin
    int hold;
    hold = 0;
    rst_n = 1'b0;
    sel_req = 1'b0;
    fix_hs = 1; fix_vs = 1; fix_de = 0; fix_d = 0;
    adp_hs = 1; adp_vs = 1; adp_de = 0; adp_d = 0;
    al_hs = 1;  al_vs = 1;  al_de = 0;  al_d = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dut", {o_hs, o_vs, o_de, o_data, o_src, o_done, o_err}, RST_VEC);
    check("reset_dut_at", {a_hs, a_vs, a_de, a_data, a_src, a_done, a_err}, RST_VEC);
    rst_n = 1'b1;

    for (int c = 0; c < CYCLES; c++) begin
      if (c > 0) @(negedge clk);
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst_n = 1'b1;
      end
      check("cyc_dut", {o_hs, o_vs, o_de, o_data, o_src, o_done, o_err}, m_exp[0]);
      check("cyc_dut_at", {a_hs, a_vs, a_de, a_data, a_src, a_done, a_err}, m_exp[1]);
      if (o_done) d_done_cnt++;
      if (o_err)  d_err_cnt++;

      if (c == 168) sel_req = 1'b1;
      else if (c == 400) sel_req = 1'b0;
      else if (c >= 900 && c < 1350 && $urandom_range(39) == 0) sel_req = ~sel_req;

      stream_ctl(c, 10, 0, fix_hs, fix_vs, fix_de);
      stream_ctl(c, 47, 1, adp_hs, adp_vs, adp_de);
      stream_ctl(c, 10, 2, al_hs, al_vs, al_de);
      fix_d = 8'($urandom);
      adp_d = 8'($urandom);
      al_d  = 8'($urandom);

      if (c == 808) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_dut", {o_hs, o_vs, o_de, o_data, o_src, o_done, o_err}, RST_VEC);
        check("rst_async_dut_at", {a_hs, a_vs, a_de, a_data, a_src, a_done, a_err}, RST_VEC);
        model_reset();
        hold = 3;
      end

      @(posedge clk);
      if (rst_n) begin
        model_step(0, 1'b0, sel_req, fix_hs, fix_vs, fix_de, fix_d, adp_hs, adp_vs, adp_de, adp_d);
        model_step(1, 1'b1, sel_req, fix_hs, fix_vs, fix_de, fix_d, al_hs, al_vs, al_de, al_d);
      end
    end

    @(negedge clk);
    check("done_pulses", d_done_cnt, m_done_cnt);
    check("err_pulses", d_err_cnt, m_err_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_stream_arbiter.md
Name: seg_stream_arbiter

Overview:
- Frame-synchronous selector that shares the single VGA capture/display port between the fixed-threshold and adaptive-threshold segmentation streams.
- Both streams run continuously. The block forwards exactly one of them, and changes source only at a frame boundary so that no partial frame reaches the output.
- Counts the forwarded pixels, flags each completed frame and flags short or long frames.
- Sits directly after the two segmentation outputs in top.

Parameters:
- H_DISP, 1440, active pixels per line.
- V_DISP, 1080, active lines per frame.
- AUTO_TOGGLE, 0, when 1 the source alternates at every frame boundary and sel_req is ignored.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel_req  in  1  requested source: 0 = fixed, 1 = adaptive
- fix_hsync  in  1  fixed stream hsync, active-low
- fix_vsync  in  1  fixed stream vsync, active-low
- fix_data  in  8  fixed stream pixel
- fix_de  in  1  fixed stream data enable
- adp_hsync  in  1  adaptive stream hsync, active-low
- adp_vsync  in  1  adaptive stream vsync, active-low
- adp_data  in  8  adaptive stream pixel
- adp_de  in  1  adaptive stream data enable
- out_hsync  out  1  forwarded hsync
- out_vsync  out  1  forwarded vsync
- out_data  out  8  forwarded pixel
- out_de  out  1  forwarded data enable
- out_src  out  1  source currently forwarded
- frame_done  out  1  1-cycle pulse on the last pixel of a complete frame
- frame_err  out  1  1-cycle pulse when the previous frame's pixel count is not H_DISP*V_DISP

Behaviour:
- Reset (asynchronous, any time including mid-frame): state IDLE, out_hsync=1, out_vsync=1, out_de=0, out_data=0, out_src=0, frame_done=0, frame_err=0, pix_cnt=0.
- Frame-start event FS(s): the registered previous fix_vsync or adp_vsync is 1 and the current value is 0 (falling edge), evaluated per source every cycle.
- Target source: tgt = AUTO_TOGGLE ? ~out_src : sel_req. In IDLE, tgt = sel_req.
- Blanked output (used in IDLE and SWITCH): hsync=1, vsync=1, de=0, data=0.
- IDLE: output blanked.
  - On FS(tgt): out_src<=tgt, pix_cnt<=0, go to RUN.
  - The frame beginning at that edge is forwarded.
- RUN: all four out_* are the selected source's inputs registered once (latency 1 cycle, no gaps).
  - On FS(out_src) with tgt==out_src: stay in RUN and continue forwarding.
  - On FS(out_src) with tgt!=out_src: go to SWITCH. From that cycle the output is blanked; the new frame of the old source is not forwarded.
  - If FS(tgt) occurs in the same cycle as FS(out_src), go directly to RUN on tgt and skip SWITCH.
- SWITCH: output blanked. On FS(tgt): out_src<=tgt, pix_cnt<=0, go to RUN.
  - If tgt changes back to out_src while in SWITCH, wait for FS of the new tgt. No timeout: the wait may last up to one frame.
- sel_req changes are sampled only at FS events. Mid-frame changes have no effect until the boundary.
- pix_cnt:
  - Width $clog2(H_DISP*V_DISP+1); 21 bits at the defaults.
  - Increments on each forwarded de=1 cycle and saturates at its maximum.
  - Cleared at every FS accepted in RUN, and on entry to RUN.
- frame_done: asserted in the same cycle out_de carries pixel number H_DISP*V_DISP, at most once per frame. Extra pixels are still forwarded.
- frame_err: pulses 1 cycle after an RUN→RUN FS(out_src) when pix_cnt != H_DISP*V_DISP.
  - Not checked on entry from IDLE or SWITCH, because no complete prior frame exists.
- hsync is passed through unchanged. The block does not validate line length.

Test Plan (H_DISP=8, V_DISP=4, so 32 pixels per frame; the two streams offset by 37 cycles):
- Reset, sel_req=0, three fix frames → output blanked until the first fix vsync fall; then out_data equals fix_data delayed 1 cycle; out_src=0; frame_done pulses on the 32nd pixel of each frame; frame_err never asserts.
- sel_req 0→1 mid-frame 2 → frame 2 completes from fix; blanking from the next fix vsync fall until the next adp vsync fall; then adp frames forwarded with out_src=1 and no torn frame.
- Fix frame truncated to 30 de pixels → no frame_done for that frame; frame_err pulses once at the next fix vsync fall; the following 32-pixel frame is clean.
- AUTO_TOGGLE=1 with streams aligned (same-cycle vsync falls) → out_src alternates 0,1,0,1 on consecutive frames with no SWITCH blanking.
- rst_n low for 3 cycles mid-frame during RUN → outputs take reset values asynchronously; IDLE resumes at the next vsync fall of the sel_req source.
- Frame of 33 de pixels → frame_done on the 32nd pixel only; 33rd pixel forwarded; frame_err at the next boundary.
